// File: rtl/fmac_exp_align.sv
// FMAC exponent alignment: bias removal, operand swap, iterative sticky shift.
// FMAC_ALIGN_FASTSAT_EN: shifts past the mantissa width complete in one cycle.
module fmac_exp_align #(
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127,
  parameter int AMAN_W = 24,
  parameter int PMAN_W = 48,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W:0]    prod_exp,
  input  logic [PMAN_W-1:0] prod_man,
  input  logic [EXP_W-1:0]  add_exp,
  input  logic [AMAN_W-1:0] add_man,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W+1:0]  exp_out,
  output logic [PMAN_W-1:0] big_man,
  output logic [PMAN_W-1:0] small_man,
  output logic              sticky,
  output logic              swapped
);

  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] STEPL = EW'(STEP);
  localparam logic [PMAN_W-1:0] ONE = PMAN_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  logic [EW-1:0] count;

  logic signed [EW-1:0] pe;
  logic signed [EW-1:0] d;
  logic              zero_add;
  logic              neg;
  logic [EW-1:0]     mag;
  logic [PMAN_W-1:0] ext_add;
  logic [PMAN_W-1:0] sel_small;
  logic [PMAN_W-1:0] sel_big;
  logic [EW-1:0]     sel_exp;
  logic              sat;
  logic [EW-1:0]     s;
  logic [PMAN_W-1:0] mask;
  logic              lost;

  assign pe = $signed({1'b0, prod_exp}) - $signed(EW'(BIAS));
  assign d  = pe - $signed({2'b00, add_exp});
  assign zero_add = (add_man == '0);
  assign neg = d[EW-1] & ~zero_add;
  assign mag = zero_add ? '0 : (neg ? -d : d);

  // Addend hidden bit lands on product bit PMAN_W-2
  assign ext_add = {1'b0, add_man, {(PMAN_W-1-AMAN_W){1'b0}}};

  assign sel_small = zero_add ? '0 : (neg ? prod_man : ext_add);
  assign sel_big   = neg ? ext_add : prod_man;
  assign sel_exp   = neg ? {2'b00, add_exp} : pe;

`ifdef FMAC_ALIGN_FASTSAT_EN
  localparam logic [EW-1:0] SATL = EW'(PMAN_W + 1);
  assign sat = (mag >= SATL);
`else
  assign sat = 1'b0;
`endif

  assign s    = (count < STEPL) ? count : STEPL;
  assign mask = (ONE << s) - ONE;
  assign lost = |(small_man & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      exp_out   <= '0;
      big_man   <= '0;
      small_man <= '0;
      sticky    <= 1'b0;
      swapped   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            exp_out   <= sel_exp;
            big_man   <= sel_big;
            swapped   <= neg;
            small_man <= sel_small;
            sticky    <= 1'b0;
            count     <= mag;
            if (mag == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (sat) begin
              small_man <= '0;
              sticky    <= |sel_small;
              count     <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          small_man <= small_man >> s;
          sticky    <= sticky | lost;
          count     <= count - s;
          if (count == s) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
